stream_pkt_arbiter: RTL and testbench
=====================================

# stream_pkt_arbiter

Packet-granular weighted round-robin arbiter and multiplexer for valid/ready streams. It shares one downstream stream port among `nReq` upstream requesters. Ownership is locked from grant until the `last` beat of the packet completes. Each requester may keep the port for up to `quota[i]` consecutive packets before priority rotates. It sits in front of shared datapath resources where per-beat arbitration would interleave packets.

## Interface
- `nReq`, default 4: number of requesters, ≥2.
- `wBits`, default 4: width of each quota entry and of the run counter.
- `dWidth`, default 32: data width per beat.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  nReq: per-requester beat valid.
- `in_last`  in  nReq: per-requester last beat of packet.
- `in_data`  in  nReq×dWidth: per-requester beat data.
- `in_ready`  out  nReq: per-requester beat accept.
- `out_valid`  out  1: downstream beat valid.
- `out_last`  out  1: downstream last flag.
- `out_data`  out  dWidth: downstream data.
- `out_ready`  in  1: downstream accept.
- `grant`  out  nReq: one-hot current owner, 0 when no owner.
- `grant_idx`  out  $clog2(nReq): index of the owner, 0 when no owner.
- `quota`  in  nReq×wBits: consecutive-packet budget per requester. A quota of 0 is treated as 1.

## Operation
- The FSM has two states: IDLE (no owner) and BUSY (owner locked).
- Registered state:
  - `state`
  - `grant`
  - `ptr` (priority pointer, $clog2(nReq) bits)
  - `run_cnt` (wBits bits): packets already completed by the current run holder.
- IDLE:
  - Winner w is the first index with `in_valid` set, scanning `ptr`, `ptr+1`, …, wrapping modulo nReq.
  - If any `in_valid` is set: register `grant = onehot(w)` and go to BUSY.
  - If w ≠ `ptr`, clear `run_cnt` to 0, because the run holder has yielded.
  - If no `in_valid` is set: stay in IDLE and hold all state.
- BUSY with owner g:
  - `out_valid = in_valid[g]`, `out_last = in_last[g]`, `out_data = in_data[g]`.
  - `in_ready[g] = out_ready`. All other `in_ready` bits are 0.
  - The owner may drop `in_valid` mid-packet. Ownership is still held and no other requester is serviced.
- Packet end is `out_valid && out_ready && out_last`. When it occurs, let q = max(`quota[g]`, 1):
  - If `run_cnt + 1 ≥ q`: set `ptr = (g+1) mod nReq` and `run_cnt = 0`.
  - Otherwise: set `ptr = g` and `run_cnt = run_cnt + 1`.
  - In both cases clear `grant` and go to IDLE.
- `quota` is sampled only at packet end. Changing it mid-packet takes effect at that packet's end.
- `run_cnt` compare is performed at wBits+1 width, so there is no overflow.
- In IDLE, or whenever `grant` = 0:
  - `out_valid = 0`, `out_last = 0`, `out_data = 0`.
  - All `in_ready` bits are 0.

## Timing
- Reset values:
  - `state` = IDLE, `grant` = 0, `grant_idx` = 0, `ptr` = 0, `run_cnt` = 0.
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0, `in_ready` = 0.
- Reset asserted mid-packet abandons ownership immediately. No beat is accepted during the reset cycle.
- Grant latency:
  - The request is seen in IDLE at cycle t.
  - `grant` is visible at t+1.
  - The first beat can transfer at t+1.
- Packet gap:
  - The last beat transfers at cycle t.
  - The FSM is IDLE at t+1, with one bubble cycle and `grant` = 0.
  - The next owner is visible at t+2.
- Single-beat packet: `in_last` is set on the first beat. BUSY lasts exactly one cycle if `out_ready` = 1.
- The data path is combinational from the owner to the output. There is no registered data stage.
- Simultaneous `in_valid` bits in IDLE are resolved only by `ptr`. There is no starvation: every valid requester is granted within nReq×(2^wBits−1) packets.

## Test plan
- Reset, then all requesters idle:
  - `grant`, `out_valid` and `in_ready` all stay 0.
  - `ptr` stays 0 for 10 cycles.
- nReq=4, quota all 1, requesters 0–3 each continuously sending 3-beat packets, `out_ready` = 1:
  - Grant order is 0,1,2,3,0,…
  - Each packet occupies 3 cycles, followed by 1 cycle with `grant` = 0.
- Weights: quota = {1,1,1,3} (index 3 = 3), all requesting:
  - Order is 0,1,2,3,3,3,0,1,…
  - `run_cnt` for requester 3 counts 0→1→2 and then clears.
- Lock under backpressure:
  - Requester 1 is granted, then drops `in_valid` for 4 cycles mid-packet, while requester 2 is valid throughout.
  - `grant` stays 0010 and `in_ready[2]` stays 0 until requester 1's last beat is accepted.
- Run yield:
  - quota[0] = 3, and requester 0 sends 1 packet then stops, while requester 2 is waiting.
  - Requester 2 is granted next and `run_cnt` clears to 0.
  - After requester 2's packet, `ptr` = 3.
- Quota 0 and mid-packet reset:
  - With quota[1] = 0, requester 1 gets exactly one packet per turn.
  - Reset asserted during beat 2 of a 4-beat packet forces `grant` = 0, `out_valid` = 0 and `ptr` = 0 on the next cycle.

Source files
------------

// File: rtl/stream_pkt_arbiter.sv
// Packet-granular weighted round-robin arbiter/mux for valid/ready streams.
// An owner keeps the downstream port from grant until its last beat, for up to quota packets in a row.
module stream_pkt_arbiter #(
   parameter int nReq   = 4,
   parameter int wBits  = 4,
   parameter int dWidth = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [nReq-1:0]           i_in_valid,
   input  logic [nReq-1:0]           i_in_last,
   input  logic [nReq*dWidth-1:0]    i_in_data,
   output logic [nReq-1:0]           o_in_ready,
   output logic                      o_out_valid,
   output logic                      o_out_last,
   output logic [dWidth-1:0]         o_out_data,
   input  logic                      i_out_ready,
   output logic [nReq-1:0]           o_grant,
   output logic [$clog2(nReq)-1:0]   o_grant_idx,
   input  logic [nReq*wBits-1:0]     i_quota,
   output logic [0:0]                o_dbg_state,
   output logic [$clog2(nReq)-1:0]   o_dbg_ptr,
   output logic [wBits-1:0]          o_dbg_run_cnt
);

   localparam int IW = $clog2(nReq);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Handshake: a beat moves on a rising edge where valid && ready are both high.
   // Valid never waits on ready; only the owner sees ready, and nobody does while reset is high.

   logic [0:0]       r_state;
   logic [nReq-1:0]  r_grant;
   logic [IW-1:0]    r_ptr;
   logic [wBits-1:0] r_run_cnt;

   logic             w_found;
   logic [IW-1:0]    w_win_idx;
   logic [IW-1:0]    w_owner_idx;
   logic             w_busy;
   logic             w_own_valid;
   logic             w_own_last;
   logic [dWidth-1:0] w_own_data;
   logic [wBits-1:0] w_own_quota;
   logic [wBits:0]   w_quota_eff;
   logic [wBits:0]   w_run_inc;
   logic             w_run_done;
   logic [IW-1:0]    w_ptr_adv;
   logic             w_pkt_end;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= nReq) s = s - nReq;
      return IW'(s);
   endfunction

   // Scan from the highest offset down so the offset nearest ptr wins.
   always_comb begin
      w_found   = 1'b0;
      w_win_idx = '0;
      for (int k = nReq - 1; k >= 0; k--) begin
         if (i_in_valid[wrap_add(r_ptr, k)]) begin
            w_found   = 1'b1;
            w_win_idx = wrap_add(r_ptr, k);
         end
      end
   end

   always_comb begin
      w_owner_idx = '0;
      w_own_valid = 1'b0;
      w_own_last  = 1'b0;
      w_own_data  = '0;
      w_own_quota = '0;
      for (int i = 0; i < nReq; i++) begin
         if (r_grant[i]) begin
            w_owner_idx = IW'(i);
            w_own_valid = i_in_valid[i];
            w_own_last  = i_in_last[i];
            w_own_data  = i_in_data[i*dWidth +: dWidth];
            w_own_quota = i_quota[i*wBits +: wBits];
         end
      end
   end

   assign w_busy = (r_state == ST_BUSY) && (|r_grant) && !reset;

   assign o_out_valid = w_busy && w_own_valid;
   assign o_out_last  = w_busy && w_own_last;
   assign o_out_data  = w_busy ? w_own_data : '0;
   assign o_in_ready  = w_busy ? (r_grant & {nReq{i_out_ready}}) : '0;

   assign o_grant       = r_grant;
   assign o_grant_idx   = w_owner_idx;
   assign o_dbg_state   = r_state;
   assign o_dbg_ptr     = r_ptr;
   assign o_dbg_run_cnt = r_run_cnt;

   assign w_pkt_end = o_out_valid && i_out_ready && o_out_last;

   // Widened by one bit so run_cnt + 1 can never wrap; a zero quota counts as one.
   assign w_quota_eff = (w_own_quota == '0) ? (wBits+1)'(1) : {1'b0, w_own_quota};
   assign w_run_inc   = {1'b0, r_run_cnt} + (wBits+1)'(1);
   assign w_run_done  = (w_run_inc >= w_quota_eff);
   assign w_ptr_adv   = (w_owner_idx == IW'(nReq - 1)) ? '0 : w_owner_idx + IW'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_ptr     <= '0;
         r_run_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state <= ST_BUSY;
                  r_grant <= {{(nReq-1){1'b0}}, 1'b1} << w_win_idx;
                  if (w_win_idx != r_ptr) r_run_cnt <= '0;
               end
            end
            ST_BUSY: begin
               if (w_pkt_end) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  if (w_run_done) begin
                     r_ptr     <= w_ptr_adv;
                     r_run_cnt <= '0;
                  end else begin
                     r_ptr     <= w_owner_idx;
                     r_run_cnt <= w_run_inc[wBits-1:0];
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Directed bench for stream_pkt_arbiter: per-requester source queues, an expected-beat
// scoreboard in predicted grant order, and logs of ptr/run_cnt after every packet end.
module tb_stream_pkt_arbiter;

   localparam int NREQ = 4;
   localparam int WB   = 4;
   localparam int DW   = 32;
   localparam int W    = DW + 1;

   logic                   clock;
   logic                   reset;
   logic [NREQ-1:0]        i_in_valid;
   logic [NREQ-1:0]        i_in_last;
   logic [NREQ*DW-1:0]     i_in_data;
   logic [NREQ-1:0]        o_in_ready;
   logic                   o_out_valid;
   logic                   o_out_last;
   logic [DW-1:0]          o_out_data;
   logic                   i_out_ready;
   logic [NREQ-1:0]        o_grant;
   logic [1:0]             o_grant_idx;
   logic [NREQ*WB-1:0]     i_quota;
   logic [0:0]             o_dbg_state;
   logic [1:0]             o_dbg_ptr;
   logic [WB-1:0]          o_dbg_run_cnt;

   stream_pkt_arbiter #(.nReq(NREQ), .wBits(WB), .dWidth(DW)) dut (
      .clock         (clock),
      .reset         (reset),
      .i_in_valid    (i_in_valid),
      .i_in_last     (i_in_last),
      .i_in_data     (i_in_data),
      .o_in_ready    (o_in_ready),
      .o_out_valid   (o_out_valid),
      .o_out_last    (o_out_last),
      .o_out_data    (o_out_data),
      .i_out_ready   (i_out_ready),
      .o_grant       (o_grant),
      .o_grant_idx   (o_grant_idx),
      .i_quota       (i_quota),
      .o_dbg_state   (o_dbg_state),
      .o_dbg_ptr     (o_dbg_ptr),
      .o_dbg_run_cnt (o_dbg_run_cnt)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] src_q[NREQ][$];
   logic [NREQ-1:0] hold;
   int pkt_id = 0;
   int ptr_log[$];
   int rc_log[$];
   logic prev_end = 1'b0;
   logic prev_idle_req = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // driver tasks
   task automatic push_pkt(input int req, input int nb, input int nexp);
      logic [W-1:0] beat;
      for (int b = 0; b < nb; b++) begin
         beat = {(b == nb - 1), 8'(req), 8'(pkt_id), 8'(b), 8'h5A};
         src_q[req].push_back(beat);
         if (b < nexp) exp_q.push_back(beat);
      end
      pkt_id++;
   endtask

   task automatic apply();
      logic [NREQ-1:0]    v;
      logic [NREQ-1:0]    l;
      logic [NREQ*DW-1:0] d;
      logic [W-1:0]       h;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (src_q[i].size() > 0 && !hold[i]) begin
            h = src_q[i][0];
            v[i] = 1'b1;
            l[i] = h[DW];
            d[i*DW +: DW] = h[DW-1:0];
         end
      end
      i_in_valid = v;
      i_in_last  = l;
      i_in_data  = d;
   endtask

   task automatic tick();
      logic [NREQ-1:0] acc;
      logic            fire;
      logic            end_seen;
      logic [W-1:0]    e;
      apply();
      @(negedge clock);
      acc      = i_in_valid & o_in_ready;
      fire     = o_out_valid & i_out_ready;
      end_seen = 1'b0;
      if (prev_end) chk("bubble_grant", 64'(o_grant), 64'd0);
      if (prev_idle_req && !reset) chk("grant_latency", 64'(o_grant != '0), 64'd1);
      if (fire) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%0h expected=none", o_out_data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", 64'({o_out_last, o_out_data}), 64'(e));
            chk("beat_grant", 64'(o_grant), 64'(4'b0001 << e[31:24]));
            chk("beat_grant_idx", 64'(o_grant_idx), 64'(e[31:24]));
         end
         end_seen = o_out_last;
      end
      prev_end      = fire && o_out_last && !reset;
      prev_idle_req = (o_grant == '0) && (|i_in_valid) && !reset;
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++)
         if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (end_seen) begin
         ptr_log.push_back(int'(o_dbg_ptr));
         rc_log.push_back(int'(o_dbg_run_cnt));
      end
   endtask

   task automatic drain(input int budget);
      int n;
      int busy;
      n = 0;
      busy = 1;
      while (busy != 0 && n < budget) begin
         tick();
         n++;
         busy = exp_q.size();
         for (int i = 0; i < NREQ; i++) busy += src_q[i].size();
      end
      chk("drain_left", 64'(busy), 64'd0);
   endtask

   task automatic check_logs(input string tag, input int n, input int ep[8], input int er[8]);
      chk({tag, "_log_size"}, 64'(ptr_log.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < ptr_log.size()) begin
            chk({tag, "_ptr"}, 64'(ptr_log[i]), 64'(ep[i]));
            chk({tag, "_run_cnt"}, 64'(rc_log[i]), 64'(er[i]));
         end
      end
      ptr_log.delete();
      rc_log.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      hold  = '0;
      apply();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      prev_end = 1'b0;
      prev_idle_req = 1'b0;
   endtask

   initial begin
      int ep[8];
      int er[8];
      reset       = 1'b1;
      hold        = '0;
      i_out_ready = 1'b1;
      i_quota     = {4'd1, 4'd1, 4'd1, 4'd1};
      apply();
      do_reset();

      // reset values
      chk("rst_grant", 64'(o_grant), 64'd0);
      chk("rst_grant_idx", 64'(o_grant_idx), 64'd0);
      chk("rst_state", 64'(o_dbg_state), 64'd0);
      chk("rst_ptr", 64'(o_dbg_ptr), 64'd0);
      chk("rst_run_cnt", 64'(o_dbg_run_cnt), 64'd0);
      chk("rst_out_valid", 64'(o_out_valid), 64'd0);
      chk("rst_out_last", 64'(o_out_last), 64'd0);
      chk("rst_out_data", 64'(o_out_data), 64'd0);
      chk("rst_in_ready", 64'(o_in_ready), 64'd0);

      // all idle for 10 cycles
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_grant", 64'(o_grant), 64'd0);
         chk("idle_out_valid", 64'(o_out_valid), 64'd0);
         chk("idle_in_ready", 64'(o_in_ready), 64'd0);
         chk("idle_ptr", 64'(o_dbg_ptr), 64'd0);
      end

      // plain round robin, 3-beat packets
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < NREQ; r++) push_pkt(r, 3, 3);
      drain(100);
      ep = '{1, 2, 3, 0, 1, 2, 3, 0};
      er = '{0, 0, 0, 0, 0, 0, 0, 0};
      check_logs("rr", 8, ep, er);

      // weights: requester 3 holds for three packets
      i_quota = {4'd3, 4'd1, 4'd1, 4'd1};
      push_pkt(0, 2, 2); push_pkt(1, 2, 2); push_pkt(2, 2, 2);
      push_pkt(3, 2, 2); push_pkt(3, 1, 1); push_pkt(3, 2, 2);
      push_pkt(0, 1, 1); push_pkt(1, 2, 2);
      drain(100);
      ep = '{1, 2, 3, 3, 3, 0, 1, 2};
      er = '{0, 0, 0, 1, 2, 0, 0, 0};
      check_logs("wrr", 8, ep, er);

      // lock under owner stall
      i_quota = {4'd1, 4'd1, 4'd1, 4'd1};
      push_pkt(1, 4, 4);
      tick();
      chk("lock_granted", 64'(o_grant), 64'b0010);
      push_pkt(2, 2, 2);
      tick();
      hold[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("lock_grant", 64'(o_grant), 64'b0010);
         chk("lock_in_ready", 64'(o_in_ready), 64'b0010);
         chk("lock_out_valid", 64'(o_out_valid), 64'd0);
      end
      hold[1] = 1'b0;
      drain(50);
      ep = '{2, 3, 0, 0, 0, 0, 0, 0};
      er = '{0, 0, 0, 0, 0, 0, 0, 0};
      check_logs("lock", 2, ep, er);

      // run yield: requester 0 leaves its run early
      do_reset();
      i_quota = {4'd1, 4'd1, 4'd1, 4'd3};
      push_pkt(0, 2, 2);
      push_pkt(2, 2, 2);
      tick();
      chk("yield_grant0", 64'(o_grant), 64'b0001);
      tick();
      tick();
      chk("yield_bubble_grant", 64'(o_grant), 64'd0);
      chk("yield_bubble_ptr", 64'(o_dbg_ptr), 64'd0);
      chk("yield_bubble_run_cnt", 64'(o_dbg_run_cnt), 64'd1);
      tick();
      chk("yield_grant2", 64'(o_grant), 64'b0100);
      chk("yield_run_cnt_clear", 64'(o_dbg_run_cnt), 64'd0);
      drain(50);
      chk("yield_ptr_after", 64'(o_dbg_ptr), 64'd3);
      chk("yield_run_cnt_after", 64'(o_dbg_run_cnt), 64'd0);
      ptr_log.delete();
      rc_log.delete();

      // quota 0 behaves as 1
      i_quota = {4'd1, 4'd1, 4'd0, 4'd1};
      push_pkt(0, 2, 2); push_pkt(1, 2, 2); push_pkt(2, 2, 2); push_pkt(1, 2, 2);
      drain(100);
      ep = '{1, 2, 3, 2, 0, 0, 0, 0};
      er = '{0, 0, 0, 0, 0, 0, 0, 0};
      check_logs("q0", 4, ep, er);

      // reset during beat 2 of a 4-beat packet
      push_pkt(0, 4, 1);
      tick();
      chk("mrst_grant", 64'(o_grant), 64'b0001);
      tick();
      reset = 1'b1;
      apply();
      #1;
      chk("mrst_in_ready", 64'(o_in_ready), 64'd0);
      chk("mrst_out_valid", 64'(o_out_valid), 64'd0);
      tick();
      reset = 1'b0;
      chk("mrst_after_grant", 64'(o_grant), 64'd0);
      chk("mrst_after_ptr", 64'(o_dbg_ptr), 64'd0);
      chk("mrst_after_out_valid", 64'(o_out_valid), 64'd0);
      chk("mrst_exp_left", 64'(exp_q.size()), 64'd0);
      src_q[0].delete();
      prev_end = 1'b0;
      prev_idle_req = 1'b0;
      tick();
      chk("mrst_quiet_grant", 64'(o_grant), 64'd0);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
